fifo_rd_pack: RTL and testbench

- Read-side consumer for the async FIFO's read port, running entirely in the read clock domain.
- Pops DSIZE-wide entries using the FIFO's first-word-fall-through read interface (rempty, rq, read_data).
- Packs RATIO consecutive entries into one wide word and presents it on a valid/ready output.
- A flush pulse emits a partial word with a lane count, so packet tails are not stranded in the accumulator.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_rd_pack_if.sv | 44 ++++
 rtl/fifo_out_reg.sv | 52 +++++
 rtl/fifo_rd_pack.sv | 127 ++++++++++++
 tb/tb_fifo_rd_pack.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side blocks.
// Holds the default entry width and the width helpers used to size the
// lane counter of the read-side packer.
package fifo_pkg;

    // Default FIFO entry width.
    localparam int DSIZE_DEF = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A counter that must hold 0..ratio inclusive needs one bit more than
    // clog2(ratio).
    function automatic int cnt_width(input int ratio);
        return clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_pack_if.sv
// Bundle of the packer's FIFO read port, flush request and packed-word
// output stream, plus two observation signals for the lane counter and the
// pending-flush bit.
//
// Handshake: a word transfers on a clock edge where out_valid and out_ready
// are both 1; while out_valid=1 and out_ready=0 the payload (out_data,
// out_cnt, out_last) holds stable and out_valid does not drop. On the FIFO
// side an entry is consumed on an edge where rq=1 and rempty=0.
//
// master : the packer (drives rq and the output stream)
// slave  : the environment (FIFO read side and downstream consumer)
interface fifo_rd_pack_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int RATIO = 4
);
    localparam int CNTW = cnt_width(RATIO);

    logic                   rempty;
    logic [DSIZE-1:0]       read_data;
    logic                   rq;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [DSIZE*RATIO-1:0] out_data;
    logic [CNTW-1:0]        out_cnt;
    logic                   out_last;
    logic [CNTW-1:0]        dbg_lane;
    logic                   dbg_flush_pend;

    modport master (
        input  rempty, read_data, flush, out_ready,
        output rq, out_valid, out_data, out_cnt, out_last,
        output dbg_lane, dbg_flush_pend
    );

    modport slave (
        output rempty, read_data, flush, out_ready,
        input  rq, out_valid, out_data, out_cnt, out_last,
        input  dbg_lane, dbg_flush_pend
    );

endinterface

// File: rtl/fifo_out_reg.sv
// Valid/ready output holding register for a generic payload.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset (clears valid and payload)
//   load_i  capture data_i; the caller only asserts it when the register is
//           empty or its current word is being accepted this cycle
//   data_i  payload to capture
//   ready_i downstream accept
//   valid_o payload valid
//   data_o  held payload
module fifo_out_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fifo_rd_pack.sv
// Read-side packer for the async FIFO. Pops entries through the FIFO's
// fall-through read port, packs RATIO of them into one wide word (first
// popped entry in the low lane) and offers it on a valid/ready stream.
// A flush pulse pushes out a partial word tagged last with its lane count.
// Ports:
//   rclk    read-domain clock
//   rrst_n  synchronous active-low reset; also forces rq low
//   bus     fifo_rd_pack_if.master: rempty/read_data/rq FIFO port, flush,
//           out_valid/out_ready/out_data/out_cnt/out_last stream, and the
//           dbg_lane / dbg_flush_pend observation outputs
module fifo_rd_pack
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int RATIO = 4
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_rd_pack_if.master bus
);

    localparam int              CNTW      = cnt_width(RATIO);
    localparam int              WW        = DSIZE * RATIO;
    localparam int              PW        = WW + CNTW + 1;
    localparam logic [CNTW-1:0] LANE_FULL = CNTW'(RATIO);

    logic [DSIZE-1:0] acc_q [RATIO];
    logic [DSIZE-1:0] acc_d [RATIO];
    logic [CNTW-1:0]  lane_q;
    logic [CNTW-1:0]  lane_d;
    logic             flush_pend_q;
    logic             flush_pend_d;

    logic             load_ok;
    logic             emit_full;
    logic             emit_part;
    logic             pop;
    logic [CNTW-1:0]  wr_lane;
    logic [WW-1:0]    word;
    logic [PW-1:0]    payload_q;

    // Control. pop already contains !rempty, so it is the FIFO's own
    // "pointer advances" condition.
    always_comb begin
        load_ok   = !bus.out_valid || bus.out_ready;
        emit_full = (lane_q == LANE_FULL) && load_ok;
        emit_part = flush_pend_q && (lane_q != '0) && (lane_q != LANE_FULL) && load_ok;
        pop       = rrst_n && !bus.rempty && !flush_pend_q &&
                    ((lane_q < LANE_FULL) || emit_full);
        // A pop coinciding with a full emit starts the next word at lane 0.
        wr_lane   = emit_full ? '0 : lane_q;
    end

    // Outgoing word: lanes at or above the current count read as zero, so
    // a partial word never exposes stale accumulator contents.
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CNTW'(i) < lane_q) begin
                word[i*DSIZE +: DSIZE] = acc_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            acc_d[i] = acc_q[i];
            if (pop && (wr_lane == CNTW'(i))) begin
                acc_d[i] = bus.read_data;
            end
        end

        lane_d = lane_q;
        if (emit_full || emit_part) begin
            lane_d = pop ? CNTW'(1) : '0;
        end else if (pop) begin
            lane_d = lane_q + CNTW'(1);
        end

        // A pending flush retires once the partial word leaves or once the
        // accumulator is empty (which also covers the case where a full
        // word drained first). A new pulse while pending is ignored.
        if (flush_pend_q) begin
            flush_pend_d = !(emit_part || (lane_q == '0));
        end else begin
            flush_pend_d = bus.flush;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            lane_q       <= '0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < RATIO; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            lane_q       <= lane_d;
            flush_pend_q <= flush_pend_d;
            for (int i = 0; i < RATIO; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Payload layout: {last, cnt, data}. During a full emit lane_q equals
    // RATIO, so lane_q is the lane count in both emit cases.
    fifo_out_reg #(
        .W(PW)
    ) u_out_reg (
        .clk_i   (rclk),
        .rst_ni  (rrst_n),
        .load_i  (emit_full || emit_part),
        .data_i  ({emit_part, lane_q, word}),
        .ready_i (bus.out_ready),
        .valid_o (bus.out_valid),
        .data_o  (payload_q)
    );

    assign bus.out_last       = payload_q[PW-1];
    assign bus.out_cnt        = payload_q[WW +: CNTW];
    assign bus.out_data       = payload_q[WW-1:0];
    assign bus.rq             = pop;
    assign bus.dbg_lane       = lane_q;
    assign bus.dbg_flush_pend = flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack (DSIZE=8, RATIO=4) with a small
// fall-through FIFO model feeding the read port.
module tb_fifo_rd_pack;

    logic clk = 1'b0;
    logic rrst_n;

    fifo_rd_pack_if #(.DSIZE(8), .RATIO(4)) bus ();

    fifo_rd_pack #(.DSIZE(8), .RATIO(4)) dut (
        .rclk   (clk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // FIFO model: fall-through head, pointer advances on rq & !rempty,
    // emptied by the shared read-domain reset.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.rempty    = (rd_ptr == wr_ptr);
    assign bus.read_data = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (!rrst_n) begin
            rd_ptr <= wr_ptr;
        end else if (bus.rq && !bus.rempty) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Capture of every accepted word: {last, cnt[2:0], data[31:0]}.
    logic [35:0] cap_q [$];

    always @(negedge clk) begin
        if (rrst_n && bus.out_valid && bus.out_ready) begin
            cap_q.push_back({bus.out_last, bus.out_cnt, bus.out_data});
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits (bounded) for one accepted word and compares it.
    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [2:0] c, input logic l);
        logic [35:0] w;
        int k;
        k = 0;
        while (cap_q.size() == 0 && k < 200) begin
            tick();
            k++;
        end
        chk({tag, "_arrived"}, (cap_q.size() > 0), 1);
        if (cap_q.size() > 0) begin
            w = cap_q.pop_front();
            chk({tag, "_data"}, w[31:0], d);
            chk({tag, "_cnt"},  w[34:32], c);
            chk({tag, "_last"}, w[35], l);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rrst_n        = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset: rq held low even with an entry available.
        push(8'h99);
        #2;
        chk("rst_rq", bus.rq, 0);
        tick_n(2);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_cnt",   bus.out_cnt, 0);
        chk("rst_last",  bus.out_last, 0);
        chk("rst_lane",  bus.dbg_lane, 0);
        chk("rst_fpend", bus.dbg_flush_pend, 0);
        rrst_n = 1'b1;
        tick();

        // One full word, rq high four cycles in a row.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w1_rq", bus.rq, 1);
            tick();
        end
        expect_word("w1", 32'h44332211, 3'd4, 1'b0);
        tick_n(4);
        chk("w1_once",  cap_q.size(), 0);
        chk("w1_valid", bus.out_valid, 0);
        chk("w1_rq_idle", bus.rq, 0);

        // Two back-to-back words, rq never drops.
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w2_rq", bus.rq, 1);
            tick();
        end
        expect_word("w2a", 32'h04030201, 3'd4, 1'b0);
        expect_word("w2b", 32'h08070605, 3'd4, 1'b0);
        tick_n(3);

        // Partial flush, no pops while the flush is pending.
        push(8'hAA); push(8'hBB);
        tick_n(2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        push(8'hCC);
        @(negedge clk);
        chk("fl_rq_pend", bus.rq, 0);
        chk("fl_pend",    bus.dbg_flush_pend, 1);
        tick();
        expect_word("fl", 32'h0000BBAA, 3'd2, 1'b1);
        tick_n(3);
        chk("fl_cc_lane", bus.dbg_lane, 1);
        // Pop in the same cycle as the flush pulse belongs to the word.
        push(8'hDD);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        expect_word("fl2", 32'h0000DDCC, 3'd2, 1'b1);
        tick_n(3);

        // Backpressure with 12 entries.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(8'(8'h20 + i));
        tick_n(14);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_data",  bus.out_data, 32'h23222120);
        chk("bp_cnt",   bus.out_cnt, 4);
        chk("bp_lane",  bus.dbg_lane, 4);
        chk("bp_rq",    bus.rq, 0);
        tick_n(5);
        chk("bp_hold",  bus.out_data, 32'h23222120);
        chk("bp_rq2",   bus.rq, 0);
        chk("bp_none",  cap_q.size(), 0);
        bus.out_ready = 1'b1;
        expect_word("bp0", 32'h23222120, 3'd4, 1'b0);
        expect_word("bp1", 32'h27262524, 3'd4, 1'b0);
        expect_word("bp2", 32'h2B2A2928, 3'd4, 1'b0);
        tick_n(4);
        chk("bp_end", cap_q.size(), 0);

        // Flush with empty accumulator: no zero-length word.
        chk("f0_lane", bus.dbg_lane, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("f0_pend", bus.dbg_flush_pend, 1);
        tick();
        chk("f0_clear", bus.dbg_flush_pend, 0);
        tick_n(4);
        chk("f0_none",  cap_q.size(), 0);
        chk("f0_valid", bus.out_valid, 0);

        // Flush with a full accumulator: full words only, never last.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        tick_n(14);
        chk("f4_lane",  bus.dbg_lane, 4);
        chk("f4_valid", bus.out_valid, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("f4_pend", bus.dbg_flush_pend, 1);
        tick_n(2);
        chk("f4_rq", bus.rq, 0);
        bus.out_ready = 1'b1;
        expect_word("f4a", 32'h33323130, 3'd4, 1'b0);
        expect_word("f4b", 32'h37363534, 3'd4, 1'b0);
        tick_n(5);
        chk("f4_none",  cap_q.size(), 0);
        chk("f4_clear", bus.dbg_flush_pend, 0);
        chk("f4_valid", bus.out_valid, 0);

        // Reset mid-operation with a held word and three lanes filled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        tick_n(7);
        chk("mr_lane",  bus.dbg_lane, 3);
        chk("mr_valid", bus.out_valid, 1);
        rrst_n = 1'b0;
        #2;
        chk("mr_rq", bus.rq, 0);
        tick();
        chk("mr_valid0", bus.out_valid, 0);
        chk("mr_lane0",  bus.dbg_lane, 0);
        chk("mr_data0",  bus.out_data, 0);
        chk("mr_rq0",    bus.rq, 0);
        rrst_n = 1'b1;
        bus.out_ready = 1'b1;
        push(8'h50); push(8'h51); push(8'h52); push(8'h53);
        expect_word("mr", 32'h53525150, 3'd4, 1'b0);
        tick_n(4);
        chk("mr_none", cap_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
